// File: rtl/dram_arbiter_pkg.sv
// dram_arbiter_pkg: shared sizes and FSM state type for the DRAM arbiter.
package dram_arbiter_pkg;

    localparam int NUM_C_DEF   = 4;
    localparam int DRAM_ADDR_W = 16;
    localparam int DRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting just after last_grant.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [IDX_W-1:0] j;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        j     = '0;
        for (int k = 1; k <= N; k++) begin
            j = IDX_W'((int'(last_grant) + k) % N);
            if (!valid && eligible[j]) begin
                grant = j;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin sharing of the single-port data DRAM between cores,
// with the loader taking the port whenever it is not mid core access.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int NUM_C  = NUM_C_DEF,
    parameter int ADDR_W = DRAM_ADDR_W,
    parameter int DATA_W = DRAM_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_C-1:0]         req,
    input  logic [NUM_C-1:0]         we,
    input  logic [NUM_C*ADDR_W-1:0]  addr,
    input  logic [NUM_C*DATA_W-1:0]  wdata,
    output logic [NUM_C-1:0]         ack,
    output logic [NUM_C*DATA_W-1:0]  rdata,
    input  logic                     com_en,
    input  logic [ADDR_W-1:0]        com_addr,
    input  logic [DATA_W-1:0]        com_data,
    output logic                     com_ready,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy
);

    localparam int IDX_W = (NUM_C > 1) ? $clog2(NUM_C) : 1;

    state_t             state;
    logic [IDX_W-1:0]   gnt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   pick;
    logic               pick_valid;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [NUM_C-1:0]   eligible;
    logic               com_go;
    logic               in_access;

    // a core whose ack is high this cycle is masked so it cannot be regranted at once
    assign eligible  = req & ~ack;
    assign in_access = (state == ACCESS);
    assign com_go    = com_en && !in_access;
    assign com_ready = rst || !in_access;
    assign busy      = (state != IDLE);

    rr_picker #(.N(NUM_C), .IDX_W(IDX_W)) u_picker (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (pick),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ack        <= '0;
            rdata      <= '0;
            last_grant <= IDX_W'(NUM_C - 1);
            gnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: if (!com_en && pick_valid) begin
                    gnt        <= pick;
                    last_grant <= pick;
                    lat_we     <= we[pick];
                    lat_addr   <= addr[pick*ADDR_W +: ADDR_W];
                    lat_wdata  <= wdata[pick*DATA_W +: DATA_W];
                    state      <= ACCESS;
                end
                ACCESS: state <= DONE;
                DONE: begin
                    ack[gnt] <= 1'b1;
                    if (!lat_we) rdata[gnt*DATA_W +: DATA_W] <= mem_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // gating with rst keeps an aborted write from reaching the memory
    always_comb begin
        mem_en    = !rst && (in_access || com_go);
        mem_we    = !rst && (in_access ? lat_we : com_go);
        mem_addr  = rst ? '0 : in_access ? lat_addr  : com_go ? com_addr : '0;
        mem_wdata = rst ? '0 : in_access ? lat_wdata : com_go ? com_data : '0;
    end

endmodule
